regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: port A (ALU result) and port B (load/memory result).
- Grants one request per cycle with a valid/ready handshake and registers the winner into a 1-cycle write stage that drives the register file's reg_write, rd and rd_data.
- Exposes a forwarding lookup so decode can bypass the staged write onto rs1_data and rs2_data.

Parameters:
- XLEN, 32, data width of write data and forwarded data
- AW, 5, register address width
- FIXED_PRIO, 0, 0 = round-robin on conflict; 1 = port A always wins

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- a_valid  in  1  port A write request
- a_rd  in  AW  port A destination register
- a_data  in  XLEN  port A write data
- a_ready  out  1  port A request accepted this cycle
- b_valid  in  1  port B write request
- b_rd  in  AW  port B destination register
- b_data  in  XLEN  port B write data
- b_ready  out  1  port B request accepted this cycle
- reg_write  out  1  register file write enable (registered)
- rd  out  AW  register file write address (registered)
- rd_data  out  XLEN  register file write data (registered)
- q_rs1  in  AW  decode source-1 address for forwarding
- q_rs2  in  AW  decode source-2 address for forwarding
- fwd_rs1_hit  out  1  staged write targets q_rs1
- fwd_rs2_hit  out  1  staged write targets q_rs2
- fwd_data  out  XLEN  staged write data (equals rd_data)
- conflict_cnt  out  16  number of cycles in which both ports requested

Behaviour:
- Reset (rst=0, async): reg_write=0, rd=0, rd_data=0, conflict_cnt=0, RR pointer=A. a_ready=b_ready=0 while rst=0.
- Reset asserted mid-write: the staged write is dropped immediately; no write reaches the register file.
- Ready/grant logic is combinational from the valid inputs and the RR pointer.
- Exactly one of a_ready/b_ready may be 1; ready=1 only when the matching valid=1.
- A transfer occurs on the clock edge where valid&&ready.
- Requesters must hold valid, rd and data stable until ready.
- Only one valid: that port is granted immediately, regardless of the pointer.
- Both valid, FIXED_PRIO=0: the pointer's port wins. After a conflict grant the pointer moves to the loser.
- Pointer is unchanged on non-conflict grants.
- Both valid, FIXED_PRIO=1: A always wins. B waits; starvation is accepted in this mode.
- Write stage, updated every cycle:
  - reg_write <= granted && granted_rd != 0; rd <= granted_rd; rd_data <= granted_data.
  - With no grant: reg_write <= 0; rd and rd_data hold their values.
- Writes to x0 are accepted (ready=1) but never written (reg_write stays 0).
- Latency: accept on edge N gives reg_write=1 during cycle N+1; register file updates at edge N+1.
- Forwarding:
  - fwd_rsX_hit = reg_write && (rd == q_rsX) && (q_rsX != 0), combinational.
  - fwd_data = rd_data.
- conflict_cnt increments by 1 each cycle with a_valid&&b_valid and saturates at 16'hFFFF.
- Same rd on both ports in a conflict: writes occur in grant order on consecutive cycles, so the later grant's data is final.
- Throughput: one write per cycle. No internal buffering beyond the write stage.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then release with no valids -> reg_write=0, rd=0, rd_data=0, conflict_cnt=0, both readies 0.
- Single A: a_valid=1, a_rd=5, a_data=0xDEADBEEF for one cycle -> a_ready=1 that cycle; next cycle reg_write=1, rd=5, rd_data=0xDEADBEEF; following cycle reg_write=0.
- Round-robin conflict (FIXED_PRIO=0): A (rd=3, 0x11) and B (rd=4, 0x22) held valid from cycle 0 -> cycle 0 grants A; cycle 1 grants B; writes appear as rd=3/0x11 then rd=4/0x22; conflict_cnt=1.
- Fixed priority (FIXED_PRIO=1): both valid for 4 cycles with A re-issuing -> b_ready=0 all 4 cycles; a_ready=1 all 4 cycles; conflict_cnt=4.
- x0 and forwarding: B writes rd=0, data=0x55 -> b_ready=1, next cycle reg_write=0. Then A writes rd=7, 0x99 with q_rs1=7, q_rs2=0 -> next cycle fwd_rs1_hit=1, fwd_rs2_hit=0, fwd_data=0x99.
- Async reset mid-write: A accepted (rd=9, 0x1) and rst pulled low between edges -> reg_write=0 immediately without a clock edge; register 9 never written.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between the ALU (A) and load (B) results,
// stages the winner for one cycle and exposes that staged write for decode-stage forwarding.
module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int FIXED_PRIO = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_rd,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [AW-1:0]   b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    output logic            reg_write,
    output logic [AW-1:0]   rd,
    output logic [XLEN-1:0] rd_data,
    input  logic [AW-1:0]   q_rs1,
    input  logic [AW-1:0]   q_rs2,
    output logic            fwd_rs1_hit,
    output logic            fwd_rs2_hit,
    output logic [XLEN-1:0] fwd_data,
    output logic [15:0]     conflict_cnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

    logic            rr_b_p0;
    logic            conflict;
    logic            grant_a;
    logic            grant_b;
    logic            granted;
    logic [AW-1:0]   gnt_rd;
    logic [XLEN-1:0] gnt_data;
    logic [15:0]     cnt_p1;
    logic            vld_p1;
    logic [AW-1:0]   rd_p1;
    logic [XLEN-1:0] data_p1;

    // Stage 0: combinational grant from the request valids and the round-robin pointer
    assign conflict = a_valid && b_valid;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst) begin
            if (conflict) begin
                if (FIXED_PRIO != 0 || !rr_b_p0) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    assign granted  = grant_a || grant_b;
    assign gnt_rd   = grant_b ? b_rd   : a_rd;
    assign gnt_data = grant_b ? b_data : a_data;
    assign a_ready  = grant_a;
    assign b_ready  = grant_b;

    // The pointer only moves on a conflict, and then it points at the port that lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_b_p0 <= 1'b0;
        end else if (conflict) begin
            rr_b_p0 <= grant_a;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_p1 <= 16'd0;
        end else if (conflict) begin
            cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    // Stage 1: registered write stage; x0 targets are accepted but never raise the write enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            rd_p1   <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= granted && (gnt_rd != '0);
            if (granted) begin
                rd_p1   <= gnt_rd;
                data_p1 <= gnt_data;
            end
        end
    end

    assign reg_write    = vld_p1;
    assign rd           = rd_p1;
    assign rd_data      = data_p1;
    assign conflict_cnt = cnt_p1;

    assign fwd_rs1_hit = vld_p1 && (rd_p1 == q_rs1) && (q_rs1 != '0);
    assign fwd_rs2_hit = vld_p1 && (rd_p1 == q_rs2) && (q_rs2 != '0);
    assign fwd_data    = data_p1;

endmodule
